// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM access controller.
// Holds the controller state encoding and the default array geometry.
// No logic; imported by ct_spsram_256x7_ctrl.
package ct_spsram_ctrl_pkg;

    localparam int CT_ADDR_WIDTH = 8;
    localparam int CT_DATA_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } ctrl_state_e;

endpackage : ct_spsram_ctrl_pkg

// File: rtl/ct_spsram_256x7_ctrl.sv
// Purpose: access controller for a 256x7 single-port SRAM; clears the array after reset/init_req, then serves reads/writes.
// Latency: read accepted in cycle N responds in N+1 (N+2 with CT_SPSRAM_CTRL_RDATA_FLOP_EN defined); SRAM pins are combinational.
// Backpressure: req_ready is low outside READY and in the cycle init_req is seen; there is no response-side backpressure.
//
// Ports:
//   forever_cpuclk / cpurst_b      clock, async active-low reset
//   init_req / init_done           restart array clear (READY only) / high in READY
//   req_vld/req_ready/req_wr/req_addr/req_wdata/req_wmask   request port, wmask active-high per bit
//   rsp_vld / rsp_data             read response strobe and data
//   sram_a/cen/gwen/wen/d, sram_q  SRAM pins (cen/gwen/wen active-low), Q valid the cycle after a read
//
// Build option: CT_SPSRAM_CTRL_RDATA_FLOP_EN registers rsp_vld/rsp_data (rsp_data then holds between reads).
module ct_spsram_256x7_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = CT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = CT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_acc;
    // High in the cycle the SRAM presents Q for a read accepted last cycle.
    logic                  rd_pend_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_acc;
        end
    end

    // Next state plus all SRAM pin muxing. Outputs decode straight from
    // state so that asserting reset forces the idle pin values at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_done = 1'b0;
        req_ready = 1'b0;
        rd_acc    = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end

            ST_INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt_q;
                sram_d    = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                // Last entry is written this cycle; the counter wraps to 0.
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                init_done = 1'b1;
                // init_req wins over a pending request: drop ready so the
                // requester keeps its request for after the clear.
                req_ready = !init_req;
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (req_vld) begin
                    sram_cen = 1'b0;
                    sram_a   = req_addr;
                    if (req_wr) begin
                        sram_gwen = 1'b0;
                        sram_wen  = ~req_wmask;
                        sram_d    = req_wdata;
                    end else begin
                        rd_acc = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
    logic                  rsp_vld_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= rd_pend_q;
            if (rd_pend_q) begin
                rsp_data_q <= sram_q;
            end
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
`else
    // Q is gated so rsp_data reads 0 whenever no response is presented,
    // including throughout reset.
    assign rsp_vld  = rd_pend_q;
    assign rsp_data = rd_pend_q ? sram_q : '0;
`endif

endmodule : ct_spsram_256x7_ctrl

// File: tb/tb_ct_spsram_256x7_ctrl.sv
// Testbench for ct_spsram_256x7_ctrl: behavioural SRAM, shadow memory and a response scoreboard.
// Responses are matched for data and arrival cycle; init sweeps are checked entry by entry.
// Honours CT_SPSRAM_CTRL_RDATA_FLOP_EN for the expected read latency.
module tb_ct_spsram_256x7_ctrl;

    localparam int         AW  = 8;
    localparam int         DW  = 7;
    localparam logic [6:0] IV  = 7'h2A;
`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
    localparam int         LAT = 2;
`else
    localparam int         LAT = 1;
`endif
    localparam logic [33:0] RST_V = {1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'h7F, 8'h00, 7'h00};
    localparam logic [23:0] IDLE_P = {1'b1, 1'b1, 7'h7F, 8'h00, 7'h00};

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          init_req, init_done;
    logic          req_vld, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_wmask;
    logic          rsp_vld;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    always #5 clk = ~clk;

    ct_spsram_256x7_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VAL  (IV)
    ) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (cpurst_b),
        .init_req      (init_req),
        .init_done     (init_done),
        .req_vld       (req_vld),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_vld       (rsp_vld),
        .rsp_data      (rsp_data),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_gwen     (sram_gwen),
        .sram_wen      (sram_wen),
        .sram_d        (sram_d),
        .sram_q        (sram_q)
    );

    // Behavioural single-port SRAM: Q updates on the edge of a read access.
    logic [DW-1:0] mem [256];
    initial sram_q = '0;
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    logic [23:0] pins;
    logic [33:0] allv;
    assign pins = {sram_cen, sram_gwen, sram_wen, sram_a, sram_d};
    assign allv = {init_done, req_ready, rsp_vld, rsp_data, pins};

    int cyc;
    always @(posedge clk or negedge cpurst_b) begin
        if (!cpurst_b) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    typedef struct {
        logic [6:0] data;
        int         cyc;
    } exp_t;
    exp_t       q[$];
    logic [6:0] shadow [256];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every response must match the oldest outstanding read.
    always @(negedge clk) begin
        exp_t e;
        if (cpurst_b && rsp_vld) begin
            chk("rsp_expected", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic init_body();
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            init_req = 1'b0;
            req_vld  = 1'b0;
            #1;
            chk("init_pins", 64'(pins), 64'({1'b0, 1'b0, 7'h00, k[7:0], IV}));
            if (k == 0 || k == 255) chk("init_busy", 64'({init_done, req_ready}), 64'(2'b00));
        end
        @(negedge clk);
        #1;
        chk("init_done", 64'({init_done, req_ready}), 64'(2'b11));
        for (int i = 0; i < 256; i++) shadow[i] = IV;
    endtask

    task automatic release_and_init();
        @(negedge clk);
        cpurst_b = 1'b1;
        #1;
        chk("idle_c0", 64'(allv), 64'(RST_V));
        init_body();
    endtask

    task automatic do_req(input logic wr, input logic [7:0] addr,
                          input logic [6:0] wdata, input logic [6:0] mask);
        @(negedge clk);
        init_req  = 1'b0;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        #1;
        chk("req_ready", 64'(req_ready), 64'(1));
        if (wr) begin
            chk("wr_pins", 64'(pins), 64'({1'b0, 1'b0, ~mask, addr, wdata}));
            shadow[addr] = (shadow[addr] & ~mask) | (wdata & mask);
        end else begin
            chk("rd_pins", 64'(pins[23:7]), 64'({1'b0, 1'b1, 7'h7F, addr}));
            q.push_back('{data: shadow[addr], cyc: cyc + LAT});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_vld  = 1'b0;
            init_req = 1'b0;
            #1;
            chk("idle_pins", 64'(pins), 64'(IDLE_P));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cpurst_b  = 1'b0;
        init_req  = 1'b0;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_vals", 64'(allv), 64'(RST_V));
        release_and_init();

        // Read of the last entry after the clear.
        do_req(1'b0, 8'hFF, 7'h00, 7'h00);
        idle(3);

        // Full write, then read on the very next cycle.
        do_req(1'b1, 8'h12, 7'h55, 7'h7F);
        do_req(1'b0, 8'h12, 7'h00, 7'h00);
        idle(3);

        // Partial write clears the low nibble: 0x55 -> 0x50.
        do_req(1'b1, 8'h12, 7'h00, 7'h0F);
        do_req(1'b0, 8'h12, 7'h00, 7'h00);
        idle(3);

        // Zero-mask write accesses the array but changes nothing.
        do_req(1'b1, 8'h12, 7'h7F, 7'h00);
        do_req(1'b0, 8'h12, 7'h00, 7'h00);
        idle(3);

        // Distinct data in 0..7, then back-to-back reads.
        for (int i = 0; i < 8; i++) do_req(1'b1, 8'(i), 7'(i * 9 + 3), 7'h7F);
        for (int i = 0; i < 8; i++) do_req(1'b0, 8'(i), 7'h00, 7'h00);
        idle(4);
`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
        chk("rsp_hold", 64'(rsp_data), 64'(shadow[7]));
`endif

        // Read just before init_req still responds; request with init_req is refused.
        do_req(1'b0, 8'h03, 7'h00, 7'h00);
        @(negedge clk);
        init_req  = 1'b1;
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h40;
        req_wdata = 7'h11;
        req_wmask = 7'h7F;
        #1;
        chk("ready_low", 64'(req_ready), 64'(0));
        chk("initreq_pins", 64'(pins), 64'(IDLE_P));
        init_body();
        idle(2);
        do_req(1'b0, 8'h03, 7'h00, 7'h00);
        do_req(1'b0, 8'h40, 7'h00, 7'h00);
        idle(3);

        // Reset while a read response is pending.
        do_req(1'b0, 8'h05, 7'h00, 7'h00);
        @(posedge clk);
        #1;
        cpurst_b = 1'b0;
        req_vld  = 1'b0;
        q.delete();
        #1;
        chk("rst_midread", 64'(allv), 64'(RST_V));
        repeat (2) @(negedge clk);
        chk("rst_hold", 64'(allv), 64'(RST_V));
        release_and_init();

        // Reset in the middle of the clear sweep; it must restart at 0.
        do_req(1'b1, 8'h20, 7'h01, 7'h7F);
        idle(1);
        @(negedge clk);
        cpurst_b = 1'b0;
        #1;
        chk("rst_a", 64'(allv), 64'(RST_V));
        @(negedge clk);
        cpurst_b = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("midinit_busy", 64'(pins[23]), 64'(0));
        cpurst_b = 1'b0;
        #1;
        chk("rst_midinit", 64'(allv), 64'(RST_V));
        release_and_init();

        do_req(1'b0, 8'h20, 7'h00, 7'h00);
        do_req(1'b0, 8'hFF, 7'h00, 7'h00);
        idle(4);
        chk("q_drained", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ct_spsram_256x7_ctrl
